// File: rtl/mod_adsr_envelope.sv
// ADSR envelope generator: unsigned fixed-point gain (1.0 = 1 << INPUT_POINT) updated once per i_tick.
// Define ENV_PEAK_HOLD_EN to add a HOLD state at the peak, lasting i_hold_ticks ticks.
module mod_adsr_envelope #(
  parameter int INPUT_WIDTH = 32,
  parameter int INPUT_POINT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_tick,
  input  logic                   i_gate,
  input  logic [INPUT_WIDTH-1:0] i_attack_step,
  input  logic [INPUT_WIDTH-1:0] i_decay_step,
  input  logic [INPUT_WIDTH-1:0] i_sustain_level,
  input  logic [INPUT_WIDTH-1:0] i_release_step,
  input  logic [15:0]            i_hold_ticks,
  output logic [INPUT_WIDTH-1:0] o_env,
  output logic                   o_valid,
  output logic                   o_active,
  output logic [2:0]             o_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DECAY   = 3'd3,
    ST_SUSTAIN = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  localparam logic [INPUT_WIDTH-1:0] ONE   = INPUT_WIDTH'(1) << INPUT_POINT;
  localparam logic [INPUT_WIDTH:0]   ONE_X = {1'b0, ONE};

`ifdef ENV_PEAK_HOLD_EN
  localparam state_e PEAK_NEXT = ST_HOLD;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
`else
  localparam state_e PEAK_NEXT = ST_DECAY;
  logic unused_hold_ticks;
  assign unused_hold_ticks = ^i_hold_ticks;
`endif

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] level_q, level_d;
  logic                   gate_q;
  logic                   valid_q;
  logic                   active_q;

  logic [INPUT_WIDTH-1:0] sustain_c;
  logic [INPUT_WIDTH:0]   attack_sum;
  logic [INPUT_WIDTH:0]   decay_floor;
  logic                   gate_rise;
  logic                   gate_fall;

  assign sustain_c   = (i_sustain_level > ONE) ? ONE : i_sustain_level;
  // One extra bit so neither the attack sum nor the decay comparison can wrap.
  assign attack_sum  = {1'b0, level_q} + {1'b0, i_attack_step};
  assign decay_floor = {1'b0, sustain_c} + {1'b0, i_decay_step};
  assign gate_rise   = i_gate & ~gate_q;
  assign gate_fall   = ~i_gate & gate_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    level_d = level_q;
`ifdef ENV_PEAK_HOLD_EN
    cnt_d   = cnt_q;
`endif
    if (gate_rise && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
      state_d = ST_ATTACK;
    end else if (gate_fall && state_q != ST_IDLE && state_q != ST_RELEASE) begin
      state_d = ST_RELEASE;
    end else if (i_tick) begin
      unique case (state_q)
        ST_IDLE: level_d = '0;
        ST_ATTACK: begin
          if (attack_sum >= ONE_X) begin
            level_d = ONE;
            state_d = PEAK_NEXT;
          end else begin
            level_d = attack_sum[INPUT_WIDTH-1:0];
          end
        end
`ifdef ENV_PEAK_HOLD_EN
        ST_HOLD: begin
          level_d = ONE;
          if (cnt_inc >= {1'b0, i_hold_ticks}) state_d = ST_DECAY;
          else                                 cnt_d   = cnt_inc[15:0];
        end
`endif
        ST_DECAY: begin
          if ({1'b0, level_q} <= decay_floor) begin
            level_d = sustain_c;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - i_decay_step;
          end
        end
        ST_SUSTAIN: level_d = sustain_c;
        ST_RELEASE: begin
          if (level_q <= i_release_step) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - i_release_step;
          end
        end
        default: begin
          level_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
`ifdef ENV_PEAK_HOLD_EN
    if (state_d != ST_HOLD) cnt_d = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      gate_q   <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
`ifdef ENV_PEAK_HOLD_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      gate_q   <= i_gate;
      valid_q  <= i_tick;
      active_q <= (state_d != ST_IDLE);
`ifdef ENV_PEAK_HOLD_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign o_env    = level_q;
  assign o_valid  = valid_q;
  assign o_active = active_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_mod_adsr_envelope.sv
// Self-checking bench for mod_adsr_envelope: directed vector table, hand sequences, randomized run vs model.
module tb_mod_adsr_envelope;

  localparam int W   = 16;
  localparam int P   = 8;
  localparam int ONE = 256;
`ifdef ENV_PEAK_HOLD_EN
  localparam int  PEAK_ST = 2;
  localparam bit  HOLD_EN = 1'b1;
`else
  localparam int  PEAK_ST = 3;
  localparam bit  HOLD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, tick, gate;
  logic [W-1:0] atk, dec, sus, rel;
  logic [15:0]  hold;
  logic [W-1:0] o_env;
  logic         o_valid, o_active;
  logic [2:0]   o_state;

  always #5 clk = ~clk;

  mod_adsr_envelope #(.INPUT_WIDTH(W), .INPUT_POINT(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_gate(gate),
    .i_attack_step(atk), .i_decay_step(dec), .i_sustain_level(sus),
    .i_release_step(rel), .i_hold_ticks(hold),
    .o_env(o_env), .o_valid(o_valid), .o_active(o_active), .o_state(o_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: level and phase as plain integers, advanced from the envelope rules.
  int m_state = 0, m_level = 0, m_cnt = 0, m_valid = 0;
  bit m_prev = 1'b0;

  task automatic model_step();
    int  sus_c;
    bit  rise, fall;
    if (rst) begin
      m_state = 0; m_level = 0; m_cnt = 0; m_valid = 0; m_prev = 1'b0;
      return;
    end
    sus_c   = (int'(sus) > ONE) ? ONE : int'(sus);
    rise    = gate && !m_prev;
    fall    = !gate && m_prev;
    m_prev  = gate;
    m_valid = tick;
    if (rise && (m_state == 0 || m_state == 5)) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 4) m_state = 5;
    else if (tick) begin
      case (m_state)
        0: m_level = 0;
        1: if (m_level + int'(atk) >= ONE) begin
             m_level = ONE;
             m_state = HOLD_EN ? 2 : 3;
           end else m_level += int'(atk);
        2: begin
             m_cnt++;
             if (m_cnt >= int'(hold)) m_state = 3;
           end
        3: if (m_level - int'(dec) <= sus_c) begin
             m_level = sus_c;
             m_state = 4;
           end else m_level -= int'(dec);
        4: m_level = sus_c;
        5: if (m_level <= int'(rel)) begin
             m_level = 0;
             m_state = 0;
           end else m_level -= int'(rel);
        default: m_state = 0;
      endcase
    end
    if (m_state != 2) m_cnt = 0;
  endtask

  // One clock: model advances on the edge, DUT outputs are compared 1ns later.
  task automatic clk_cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model env", int'(o_env), m_level);
    check("model state", int'(o_state), m_state);
    check("model valid", int'(o_valid), m_valid);
    check("model active", int'(o_active), int'(m_state != 0));
  endtask

  typedef struct {
    bit gate;
    bit tick;
    int sus;
    int exp_env;
    int exp_state;
    bit exp_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit g, bit t, int s, int e, int st, bit v);
    vec_t x;
    x.gate = g; x.tick = t; x.sus = s; x.exp_env = e; x.exp_state = st; x.exp_valid = v;
    vecs.push_back(x);
  endfunction

  function automatic logic [W-1:0] rnd_step();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(1, 80));
      2:       return W'($urandom_range(1, 300));
      default: return W'($urandom_range(0, 65535));
    endcase
  endfunction

  int exp_env_seq[$];
  int exp_st_seq[$];

  initial begin
    rst = 1'b1; tick = 1'b1; gate = 1'b1;
    atk = 16'd64; dec = 16'd48; sus = 16'd128; rel = 16'd50; hold = 16'd0;

    // Reset held two cycles with gate high and a concurrent tick.
    repeat (2) clk_cycle();
    check("reset env", int'(o_env), 0);
    check("reset valid", int'(o_valid), 0);
    check("reset active", int'(o_active), 0);
    check("reset state", int'(o_state), 0);
    rst = 1'b0; tick = 1'b0;
    clk_cycle();
    check("post-reset attack", int'(o_state), 1);
    check("post-reset valid", int'(o_valid), 0);

    // Attack, decay, sustain, release, retrigger.
    add(1, 1, 128,  64, 1, 1);
    add(1, 1, 128, 128, 1, 1);
    add(1, 1, 128, 192, 1, 1);
    add(1, 1, 128, 256, PEAK_ST, 1);
`ifdef ENV_PEAK_HOLD_EN
    add(1, 1, 128, 256, 3, 1);
`endif
    add(1, 1, 128, 208, 3, 1);
    add(1, 1, 128, 160, 3, 1);
    add(1, 1, 128, 128, 4, 1);
    add(1, 1, 128, 128, 4, 1);
    add(1, 1, 300, 256, 4, 1);
    add(1, 1, 128, 128, 4, 1);
    add(0, 1, 128, 128, 5, 1);
    add(0, 1, 128,  78, 5, 1);
    add(0, 1, 128,  28, 5, 1);
    add(0, 1, 128,   0, 0, 1);
    add(0, 1, 128,   0, 0, 1);
    add(1, 0, 128,   0, 1, 0);
    add(1, 1, 128,  64, 1, 1);
    add(1, 1, 128, 128, 1, 1);
    add(0, 0, 128, 128, 5, 0);
    add(0, 1, 128,  78, 5, 1);
    add(1, 1, 128,  78, 1, 1);
    add(1, 1, 128, 142, 1, 1);
    add(1, 1, 128, 206, 1, 1);
    add(1, 1, 128, 256, PEAK_ST, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      gate = vecs[i].gate; tick = vecs[i].tick; sus = W'(vecs[i].sus);
      clk_cycle();
      check($sformatf("vec%0d env", i), int'(o_env), vecs[i].exp_env);
      check($sformatf("vec%0d state", i), int'(o_state), vecs[i].exp_state);
      check($sformatf("vec%0d valid", i), int'(o_valid), int'(vecs[i].exp_valid));
      tick = 1'b0;
      repeat (3) clk_cycle();
      check($sformatf("vec%0d gap valid", i), int'(o_valid), 0);
    end

    // Reset overrides a concurrent gate edge and tick.
    gate = 1'b0; tick = 1'b1; rst = 1'b1;
    clk_cycle();
    check("rst override state", int'(o_state), 0);
    check("rst override env", int'(o_env), 0);
    check("rst override valid", int'(o_valid), 0);
    rst = 1'b0; tick = 1'b0;
    clk_cycle();

    // Zero attack step stalls the level.
    gate = 1'b1; atk = 16'd0;
    clk_cycle();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      clk_cycle();
      check($sformatf("stall%0d env", i), int'(o_env), 0);
      check($sformatf("stall%0d state", i), int'(o_state), 1);
      tick = 1'b0;
      repeat (3) clk_cycle();
    end
    atk = 16'd64;

`ifdef ENV_PEAK_HOLD_EN
    // Peak hold: three ticks at ONE, then a zero-length hold.
    rst = 1'b1; clk_cycle();
    rst = 1'b0; gate = 1'b1; hold = 16'd3; atk = 16'd128;
    clk_cycle();
    exp_env_seq = '{128, 256, 256, 256, 256};
    exp_st_seq  = '{1, 2, 2, 2, 3};
    for (int i = 0; i < exp_env_seq.size(); i++) begin
      tick = 1'b1; clk_cycle();
      check($sformatf("hold3 t%0d env", i), int'(o_env), exp_env_seq[i]);
      check($sformatf("hold3 t%0d state", i), int'(o_state), exp_st_seq[i]);
      tick = 1'b0; repeat (3) clk_cycle();
    end
    rst = 1'b1; clk_cycle();
    rst = 1'b0; hold = 16'd0; atk = 16'd256;
    clk_cycle();
    exp_env_seq = '{256, 256};
    exp_st_seq  = '{2, 3};
    for (int i = 0; i < exp_env_seq.size(); i++) begin
      tick = 1'b1; clk_cycle();
      check($sformatf("hold0 t%0d env", i), int'(o_env), exp_env_seq[i]);
      check($sformatf("hold0 t%0d state", i), int'(o_state), exp_st_seq[i]);
      tick = 1'b0; repeat (3) clk_cycle();
    end
`endif

    // Randomized run against the model.
    for (int c = 0; c < 2000; c++) begin
      if (c % 60 == 0) begin
        atk  = rnd_step();
        dec  = rnd_step();
        rel  = rnd_step();
        sus  = W'($urandom_range(0, 400));
        hold = 16'($urandom_range(0, 4));
      end
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      rst  = ($urandom_range(0, 199) == 0);
      clk_cycle();
    end
    rst = 1'b0; tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
